rr_arbiter_4_amisha: RTL and testbench
======================================

// Module: rr_arbiter_4_amisha
// PURPOSE
//  4-requester round-robin arbiter with bounded grant tenure. Produces the
//  2-bit grant index plus grant-valid strobe that drive the 2-to-4 decoder's
//  select and enable inputs; the decoder's one-hot output is the per-requester
//  grant bus. Registered outputs, so the decoder sees glitch-free select/enable.
// PARAMETERS
//  MAX_HOLD  8                    max consecutive cycles one grant may last (>=1)
//  CNT_W     $clog2(MAX_HOLD)+1   width of tenure counter (derived, do not override)
// PORTS
//  clk_amisha          in   1  clock, all logic on rising edge
//  rst_amisha          in   1  reset, synchronous, active-high
//  req_amisha          in   4  request per requester, level, bit i = requester i
//  grant_idx_amisha    out  2  index of current grantee -> decoder select
//  grant_valid_amisha  out  1  grant active -> decoder enable
//  timeout_amisha      out  1  1-cycle pulse: grant ended by MAX_HOLD expiry
// BEHAVIOUR
//  Clock and reset: one clock, clk_amisha. Reset is synchronous and active-high
//   on rst_amisha.
//  Reset (rst_amisha=1 at edge, overrides all):
//   - state=IDLE, grant_valid=0, grant_idx=0, timeout=0, hold_cnt=0.
//   - last_ptr=3, so requester 0 wins first.
//  Priority search: from base b, order is b+1, b+2, b+3, b (mod 4).
//   The first set req bit wins.
//  IDLE:
//   - grant_valid=0; grant_idx keeps its last value.
//   - If req!=0: winner = search(last_ptr). Next edge: grant_idx=winner,
//     grant_valid=1, hold_cnt=0, state->GRANT.
//   - Latency req->grant_valid = 1 cycle.
//  GRANT: each cycle evaluate release.
//   - rel_drop = !req[grant_idx]; rel_to = (hold_cnt==MAX_HOLD-1) && !rel_drop.
//   - No release: hold_cnt++ (never wraps; bounded by MAX_HOLD-1).
//   - On release:
//     - last_ptr = grant_idx. Winner = search(grant_idx) over current req.
//       The current grantee is eligible only as last choice.
//     - Winner exists: next edge grant_idx=winner, grant_valid stays 1,
//       hold_cnt=0, stay GRANT. No bubble cycle.
//     - No winner: grant_valid=0, state->IDLE.
//   - timeout pulses high for exactly 1 cycle, on the edge following a rel_to
//     cycle. It is 0 otherwise, including on rel_drop.
//  Grant tenure:
//   - Lasts at most MAX_HOLD cycles of grant_valid=1 with a given index.
//   - The sole requester holding req high is regranted after timeout.
//     It gets the same idx, hold_cnt restarts, and timeout still pulses.
//  Simultaneous events:
//   - Drop and expiry in the same cycle count as rel_drop (no timeout).
//   - Requests asserting during a grant wait; they are considered only at
//     release.
//  Reset mid-grant: grant_valid=0 at the next edge, arbitration restarts from
//   requester 0.
//  MAX_HOLD=1: every grant lasts 1 cycle. With all requesting, index rotates
//   every cycle and timeout is high every cycle.
//  req changes on non-granted bits never affect the current grant.
// TESTING
//  1 rst=1 for 2 cycles, req=4'b1111 -> grant_valid=0, grant_idx=0, timeout=0
//    throughout reset.
//  2 req=0001 for 3 cycles then 0 -> grant_valid=1, idx=0 from cycle+1 for
//    3 cycles, then 0. timeout never asserted.
//  3 MAX_HOLD=8, req=1111 held -> idx 0,1,2,3,0 each for 8 cycles, no gaps.
//    timeout pulse after each tenure.
//  4 req=0101, requester 0 drops after 3 granted cycles -> idx=2 on the very
//    next cycle, grant_valid never drops, timeout=0.
//  5 req=1111, rst=1 at 4th cycle of grant to idx 1 -> grant_valid=0 next edge.
//    After release, first grant is idx 0.
//  6 MAX_HOLD=1, req=1000 held -> idx=3, grant_valid=1 continuously,
//    timeout=1 every cycle after the first grant cycle.

Source files
------------

// File: rtl/rr_arbiter_4_amisha.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4_amisha
//
// Four-requester round-robin arbiter with a bounded grant tenure. It produces
// a registered 2-bit grant index and grant-valid strobe. These drive the select
// and enable inputs of a 2-to-4 decoder. Because the outputs are registered,
// the decoder sees glitch-free select/enable.
//
// Parameters
//   MAX_HOLD  maximum consecutive cycles one grant may last (>= 1)
//   CNT_W     width of the tenure counter (derived from MAX_HOLD)
//
// Ports
//   clk_amisha          in   1  clock, all logic on rising edge
//   rst_amisha          in   1  synchronous active-high reset
//   req_amisha          in   4  level request, bit i = requester i
//   grant_idx_amisha    out  2  index of current grantee (decoder select)
//   grant_valid_amisha  out  1  grant active (decoder enable)
//   timeout_amisha      out  1  one-cycle pulse: grant ended by tenure expiry
// -----------------------------------------------------------------------------
module rr_arbiter_4_amisha #(
    parameter int MAX_HOLD = 8,
    localparam int CNT_W   = $clog2(MAX_HOLD) + 1
) (
    input  logic       clk_amisha,
    input  logic       rst_amisha,
    input  logic [3:0] req_amisha,
    output logic [1:0] grant_idx_amisha,
    output logic       grant_valid_amisha,
    output logic       timeout_amisha
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_reg,       state_next;
    logic [1:0]       grant_idx_reg,   grant_idx_next;
    logic             grant_valid_reg, grant_valid_next;
    logic             timeout_reg,     timeout_next;
    logic [CNT_W-1:0] hold_cnt_reg,    hold_cnt_next;
    logic [1:0]       last_ptr_reg,    last_ptr_next;

    logic             rel_drop;
    logic             rel_to;
    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       search_base;

    // Round-robin search: candidates base+1, base+2, base+3, then base itself,
    // so the previous owner is only picked when nobody else is asking.
    function automatic logic [2:0] rr_search(input logic [1:0] base,
                                             input logic [3:0] r);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = base;
        for (int k = 1; k <= 4; k++) begin
            cand = base + k[1:0];
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // In IDLE the search starts after the last released grantee; in GRANT it
    // starts after the current grantee (which is being released).
    assign search_base          = (state_reg == ST_GRANT) ? grant_idx_reg : last_ptr_reg;
    assign {win_found, win_idx} = rr_search(search_base, req_amisha);

    // A drop takes precedence over expiry in the same cycle, so no timeout.
    assign rel_drop = !req_amisha[grant_idx_reg];
    assign rel_to   = (hold_cnt_reg == HOLD_LAST) && !rel_drop;

    always_comb begin
        state_next       = state_reg;
        grant_idx_next   = grant_idx_reg;
        grant_valid_next = grant_valid_reg;
        timeout_next     = 1'b0;
        hold_cnt_next    = hold_cnt_reg;
        last_ptr_next    = last_ptr_reg;

        case (state_reg)
            ST_IDLE: begin
                grant_valid_next = 1'b0;
                if (win_found) begin
                    grant_idx_next   = win_idx;
                    grant_valid_next = 1'b1;
                    hold_cnt_next    = '0;
                    state_next       = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel_drop || rel_to) begin
                    last_ptr_next = grant_idx_reg;
                    timeout_next  = rel_to;
                    hold_cnt_next = '0;
                    if (win_found) begin
                        // Hand over directly: no idle bubble between grants.
                        grant_idx_next   = win_idx;
                        grant_valid_next = 1'b1;
                    end else begin
                        grant_valid_next = 1'b0;
                        state_next       = ST_IDLE;
                    end
                end else begin
                    grant_valid_next = 1'b1;
                    hold_cnt_next    = hold_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next       = ST_IDLE;
                grant_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_amisha) begin
        if (rst_amisha) begin
            state_reg       <= ST_IDLE;
            grant_idx_reg   <= 2'd0;
            grant_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            hold_cnt_reg    <= '0;
            last_ptr_reg    <= 2'd3;   // requester 0 wins first after reset
        end else begin
            state_reg       <= state_next;
            grant_idx_reg   <= grant_idx_next;
            grant_valid_reg <= grant_valid_next;
            timeout_reg     <= timeout_next;
            hold_cnt_reg    <= hold_cnt_next;
            last_ptr_reg    <= last_ptr_next;
        end
    end

    assign grant_idx_amisha   = grant_idx_reg;
    assign grant_valid_amisha = grant_valid_reg;
    assign timeout_amisha     = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_4_amisha.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_4_amisha
//
// Directed bench for the round-robin arbiter. It uses two instances: one with
// the default MAX_HOLD=8 and one with MAX_HOLD=1. Inputs change 1 time unit
// after each rising edge, and outputs are sampled at that same point. As a
// result, every check observes the registers loaded by the edge just taken.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_4_amisha;

    logic       clk;
    logic       rst;
    logic [3:0] req8;
    logic [3:0] req1;
    logic [1:0] idx8,   idx1;
    logic       valid8, valid1;
    logic       to8,    to1;

    int vec_cnt = 0;
    int err_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter_4_amisha #(.MAX_HOLD(8)) u_dut8 (
        .clk_amisha         (clk),
        .rst_amisha         (rst),
        .req_amisha         (req8),
        .grant_idx_amisha   (idx8),
        .grant_valid_amisha (valid8),
        .timeout_amisha     (to8)
    );

    rr_arbiter_4_amisha #(.MAX_HOLD(1)) u_dut1 (
        .clk_amisha         (clk),
        .rst_amisha         (rst),
        .req_amisha         (req1),
        .grant_idx_amisha   (idx1),
        .grant_valid_amisha (valid1),
        .timeout_amisha     (to1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b | d8 req=%b idx=%0d v=%b to=%b | d1 req=%b idx=%0d v=%b to=%b",
                 $time, rst, req8, idx8, valid8, to8, req1, idx1, valid1, to1);
    endtask

    // One-cycle reset on both instances, leaving rst low afterwards.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk8(input string tag, input logic [1:0] e_idx, input logic e_v, input logic e_to);
        check({tag, ".idx"},   32'(idx8),   32'(e_idx));
        check({tag, ".valid"}, 32'(valid8), 32'(e_v));
        check({tag, ".to"},    32'(to8),    32'(e_to));
    endtask

    task automatic chk1(input string tag, input logic [1:0] e_idx, input logic e_v, input logic e_to);
        check({tag, ".idx"},   32'(idx1),   32'(e_idx));
        check({tag, ".valid"}, 32'(valid1), 32'(e_v));
        check({tag, ".to"},    32'(to1),    32'(e_to));
    endtask

    initial begin
        rst  = 1'b1;
        req8 = 4'b1111;
        req1 = 4'b0000;

        // 1: reset held for two cycles with all requesting.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk8("reset", 2'd0, 1'b0, 1'b0);
        end
        rst  = 1'b0;
        req8 = 4'b0001;

        // 2: req0 high for three cycles, then dropped.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk8("single", 2'd0, 1'b1, 1'b0);
        end
        req8 = 4'b0000;
        tick();
        chk8("single_rel", 2'd0, 1'b0, 1'b0);

        // 3: all requesting; 8-cycle tenures rotating 0,1,2,3,0 with no gaps.
        req8 = 4'b1111;
        do_reset();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                chk8("rotate", 2'(g % 4), 1'b1, (c == 0) && (g > 0));
            end
        end

        // 4: req0 drops after 3 granted cycles; req2 takes over without a bubble.
        req8 = 4'b0101;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk8("drop_pre", 2'd0, 1'b1, 1'b0);
        end
        req8 = 4'b0100;
        tick();
        chk8("drop_hand", 2'd2, 1'b1, 1'b0);
        tick();
        chk8("drop_hold", 2'd2, 1'b1, 1'b0);
        req8 = 4'b0000;
        tick();
        chk8("drop_idle", 2'd2, 1'b0, 1'b0);

        // 5: reset during the 4th cycle of a grant to requester 1.
        req8 = 4'b0010;
        do_reset();
        tick();
        chk8("rst_mid_g", 2'd1, 1'b1, 1'b0);
        req8 = 4'b1111;
        for (int c = 1; c < 4; c++) begin
            tick();
            chk8("rst_mid_g", 2'd1, 1'b1, 1'b0);
        end
        rst = 1'b1;
        tick();
        chk8("rst_mid_r", 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk8("rst_mid_first", 2'd0, 1'b1, 1'b0);

        // Sole requester regranted after expiry; then drop coincides with expiry.
        req8 = 4'b0001;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            tick();
            chk8("sole", 2'd0, 1'b1, c == 8);
        end
        req8 = 4'b0000;   // this edge both expires (hold=7) and drops
        tick();
        chk8("drop_at_exp", 2'd0, 1'b0, 1'b0);

        // 6: MAX_HOLD=1 with a single requester 3 held.
        req1 = 4'b1000;
        tick();
        chk1("mh1_first", 2'd3, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk1("mh1_sole", 2'd3, 1'b1, 1'b1);
        end
        // All requesting: index rotates every cycle, timeout every cycle.
        req1 = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk1("mh1_rot", 2'(c % 4), 1'b1, 1'b1);
        end
        // Requester 1 is the grantee now; dropping all gives a drop release.
        req1 = 4'b0000;
        tick();
        chk1("mh1_drop", 2'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
